// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: holds the PLL in reset, releases it, waits for a stable
// lock with a timeout, and raises ready once lock has held long enough.
module pll_reset_sequencer #(
    parameter int HOLD_CYCLES   = 16,
    parameter int LOCK_TIMEOUT  = 12000,
    parameter int STABLE_CYCLES = 1200,
    parameter int CW            = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_resetb,
    output logic       ready,
    output logic       timeout,
    output logic       lock_lost,
    output logic [7:0] retry_count,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_WAIT   = 2'd1,
        S_STABLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_ZERO    = '0;
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_sync1;
    logic          r_sync2;
    logic          w_lock_s;
    logic          r_timeout;
    logic          w_timeout_nxt;
    logic          r_lock_lost;
    logic          w_lock_lost_nxt;
    logic [7:0]    r_retry;
    logic          w_retry_inc;

    // pll_lock is asynchronous; only the second synchronizer stage is used.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_lock;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lock_s = r_sync2;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_timeout_nxt   = 1'b0;
        w_lock_lost_nxt = 1'b0;
        w_retry_inc     = 1'b0;
        case (r_state)
            S_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_WAIT: begin
                // Lock seen on the final timeout cycle still wins.
                if (w_lock_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = CNT_ONE;
                end else if (r_cnt == WAIT_LAST) begin
                    w_state_nxt   = S_HOLD;
                    w_cnt_nxt     = CNT_ZERO;
                    w_timeout_nxt = 1'b1;
                    w_retry_inc   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt     = S_HOLD;
                    w_cnt_nxt       = CNT_ZERO;
                    w_lock_lost_nxt = 1'b1;
                    w_retry_inc     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_HOLD;
            r_cnt       <= CNT_ZERO;
            r_timeout   <= 1'b0;
            r_lock_lost <= 1'b0;
            r_retry     <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_timeout   <= w_timeout_nxt;
            r_lock_lost <= w_lock_lost_nxt;
            if (w_retry_inc && (r_retry != 8'hFF)) begin
                r_retry <= r_retry + 8'd1;
            end
        end
    end

    // All outputs come from registers or a decode of the registered state.
    assign pll_resetb  = (r_state != S_HOLD);
    assign ready       = (r_state == S_RUN);
    assign timeout     = r_timeout;
    assign lock_lost   = r_lock_lost;
    assign retry_count = r_retry;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed lock scenarios, expected output
// events queued by the driver and matched by a negedge monitor.
module tb_pll_reset_sequencer;

    localparam logic [2:0] EV_RSTB_FALL  = 3'd0;
    localparam logic [2:0] EV_RSTB_RISE  = 3'd1;
    localparam logic [2:0] EV_READY_RISE = 3'd2;
    localparam logic [2:0] EV_READY_FALL = 3'd3;
    localparam logic [2:0] EV_TIMEOUT    = 3'd4;
    localparam logic [2:0] EV_LOCK_LOST  = 3'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_resetb;
    logic       ready;
    logic       timeout;
    logic       lock_lost;
    logic [7:0] retry_count;
    logic [1:0] o_dbg_state;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Event word: {kind, retry_count, cycle stamp}
    logic [26:0] exp_q[$];

    pll_reset_sequencer #(
        .HOLD_CYCLES  (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .CW           (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .pll_resetb (pll_resetb),
        .ready      (ready),
        .timeout    (timeout),
        .lock_lost  (lock_lost),
        .retry_count(retry_count),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [26:0] ev(input logic [2:0] k, input int r, input int c);
        int rs;
        rs = (r > 255) ? 255 : r;
        return {k, 8'(rs), 16'(c)};
    endfunction

    task automatic push_ev(input logic [2:0] k, input int r, input int c);
        exp_q.push_back(ev(k, r, c));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_ev(input logic [2:0] k);
        logic [26:0] act;
        logic [26:0] exp;
        act = {k, retry_count, 16'(cyc)};
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event: unexpected kind=%0d retry=%0d cyc=%0d", k, retry_count, cyc);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                fails++;
                $display("FAIL event: got kind=%0d retry=%0d cyc=%0d expected kind=%0d retry=%0d cyc=%0d",
                         act[26:24], act[23:16], act[15:0], exp[26:24], exp[23:16], exp[15:0]);
            end
        end
    endtask

    // Monitor: detects output transitions and pulses at the falling edge.
    logic mon_init = 1'b0;
    logic prev_rstb;
    logic prev_ready;

    always @(negedge clk) begin
        if (!mon_init) begin
            if (cyc >= 1) begin
                prev_rstb  = pll_resetb;
                prev_ready = ready;
                mon_init   = 1'b1;
            end
        end else begin
            if (prev_rstb && !pll_resetb) mon_ev(EV_RSTB_FALL);
            if (!prev_rstb && pll_resetb) mon_ev(EV_RSTB_RISE);
            if (!prev_ready && ready)     mon_ev(EV_READY_RISE);
            if (prev_ready && !ready)     mon_ev(EV_READY_FALL);
            if (timeout)                  mon_ev(EV_TIMEOUT);
            if (lock_lost)                mon_ev(EV_LOCK_LOST);
            prev_rstb  = pll_resetb;
            prev_ready = ready;
        end
    end

    initial begin
        int r0;
        int t0;
        int rk;

        // Reset for 3 cycles with lock low.
        reset    = 1'b1;
        pll_lock = 1'b0;
        step(3);
        check_val("reset_pll_resetb", int'(pll_resetb), 0);
        check_val("reset_ready", int'(ready), 0);
        check_val("reset_timeout", int'(timeout), 0);
        check_val("reset_lock_lost", int'(lock_lost), 0);
        check_val("reset_retry", int'(retry_count), 0);

        // Release: pll_resetb stays low exactly 4 cycles.
        t0 = cyc;
        push_ev(EV_RSTB_RISE, 0, t0 + 4);
        reset = 1'b0;
        step(3);
        check_val("hold_pll_resetb_low", int'(pll_resetb), 0);
        step(1);

        // Lock rises 5 cycles into WAIT: ready 2 + 1 + 8 cycles later.
        step(5);
        t0 = cyc;
        push_ev(EV_READY_RISE, 0, t0 + 11);
        pll_lock = 1'b1;
        step(11);
        check_val("first_lock_ready", int'(ready), 1);

        // One-cycle lock drop in RUN.
        t0 = cyc;
        push_ev(EV_RSTB_FALL, 1, t0 + 3);
        push_ev(EV_READY_FALL, 1, t0 + 3);
        push_ev(EV_LOCK_LOST, 1, t0 + 3);
        push_ev(EV_RSTB_RISE, 1, t0 + 7);
        push_ev(EV_READY_RISE, 1, t0 + 16);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(15);
        check_val("reacquire_retry", int'(retry_count), 1);

        // Drop lock for good, then a short lock that falls during STABLE.
        t0 = cyc;
        push_ev(EV_RSTB_FALL, 2, t0 + 3);
        push_ev(EV_READY_FALL, 2, t0 + 3);
        push_ev(EV_LOCK_LOST, 2, t0 + 3);
        push_ev(EV_RSTB_RISE, 2, t0 + 7);
        pll_lock = 1'b0;
        step(9);
        pll_lock = 1'b1;
        step(5);
        pll_lock = 1'b0;
        step(3);
        check_val("stable_drop_no_ready", int'(ready), 0);
        t0 = cyc;
        push_ev(EV_READY_RISE, 2, t0 + 11);
        pll_lock = 1'b1;
        step(11);
        check_val("stable_drop_retry", int'(retry_count), 2);

        // Lock lost, never returns: 300 timeouts, one every 24 cycles.
        t0 = cyc;
        push_ev(EV_RSTB_FALL, 3, t0 + 3);
        push_ev(EV_READY_FALL, 3, t0 + 3);
        push_ev(EV_LOCK_LOST, 3, t0 + 3);
        push_ev(EV_RSTB_RISE, 3, t0 + 7);
        r0 = t0 + 7;
        for (int k = 1; k <= 300; k++) begin
            rk = r0 + 24 * k;
            push_ev(EV_RSTB_FALL, 3 + k, rk - 4);
            push_ev(EV_TIMEOUT, 3 + k, rk - 4);
            push_ev(EV_RSTB_RISE, 3 + k, rk);
        end
        pll_lock = 1'b0;
        step(7 + 24 * 300);
        check_val("retry_saturated", int'(retry_count), 255);

        // Lock, then reset in the middle of STABLE.
        pll_lock = 1'b1;
        step(5);
        check_val("mid_stable_state", int'(o_dbg_state), 2);
        t0 = cyc;
        push_ev(EV_RSTB_FALL, 0, t0 + 1);
        reset = 1'b1;
        step(1);
        check_val("midreset_pll_resetb", int'(pll_resetb), 0);
        check_val("midreset_ready", int'(ready), 0);
        check_val("midreset_timeout", int'(timeout), 0);
        check_val("midreset_lock_lost", int'(lock_lost), 0);
        check_val("midreset_retry", int'(retry_count), 0);
        check_val("midreset_state", int'(o_dbg_state), 0);

        // Recovery after reset with lock already high.
        t0 = cyc;
        push_ev(EV_RSTB_RISE, 0, t0 + 4);
        push_ev(EV_READY_RISE, 0, t0 + 13);
        reset = 1'b0;
        step(13);
        check_val("post_reset_ready", int'(ready), 1);
        step(3);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_events: got %0d outstanding expected 0, first kind=%0d cyc=%0d",
                     exp_q.size(), exp_q[0][26:24], exp_q[0][15:0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
